he_mul_driver: RTL
==================

# he_mul_driver

Synthesizable initiator for the `functional` ciphertext-multiply core. Accepts a serial stream of coefficients, assembles the four input polynomials (ct00, ct01, ct10, ct11), and issues a one-cycle `start` to the core. It then waits for `valid`, captures both result polynomials and streams them back out coefficient by coefficient. It sits between the host/DMA word stream and `functional`, and replaces the bench-side driving logic in silicon.

## Interface
Parameters: none. Sizes come from `DEGREE_N` (coefficients per polynomial, N) and `BIT_WIDTH` (bits per coefficient, W), both from `he_headers.sv`.

Ports:
- `clk`  in  1  sole clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_t`  in  W  plaintext modulus for the next job.
- `cfg_q`  in  W  ciphertext modulus for the next job.
- `in_valid`  in  1  input coefficient valid.
- `in_ready`  out  1  block can accept a coefficient.
- `in_data`  in  W  input coefficient.
- `t_o`, `q_o`  out  W each  latched moduli to the core.
- `start_o`  out  1  one-cycle job start to the core.
- `ct00_o`, `ct01_o`, `ct10_o`, `ct11_o`  out  N×W each  packed polynomials to the core.
- `valid_i`  in  1  core result valid.
- `res_i`  in  [1:0] of N×W  core result polynomials.
- `out_valid`  out  1  output coefficient valid.
- `out_ready`  in  1  downstream accepts the output coefficient.
- `out_data`  out  W  output coefficient.
- `out_last`  out  1  marks the final (2N-th) output beat.
- `busy_o`  out  1  high in every state except LOAD.

## Operation
- States:
  - LOAD: `in_ready=1`. An input beat is accepted when `in_valid && in_ready`. Beat k (0..4N-1) is written to polynomial k/N, coefficient k%N. Order is ct00, ct01, ct10, ct11, coefficient 0 first.
  - FIRE: exactly 1 cycle, `start_o=1`.
  - WAIT: hold until `valid_i`.
  - DRAIN: stream the results out.
- Transitions:
  - LOAD→FIRE after the 4N-th accepted beat.
  - FIRE→WAIT unconditionally.
  - WAIT→DRAIN on the cycle `valid_i=1`. On that edge `res_i[0]` and `res_i[1]` are captured into the result buffer.
  - DRAIN→LOAD after the 2N-th output handshake.
- `cfg_t`/`cfg_q` are sampled on the first accepted beat (k=0) and held on `t_o`/`q_o` until the next job's first beat.
- Output order: res[0] coefficients 0..N-1, then res[1] coefficients 0..N-1. `out_data` is a registered buffer read.
- `out_valid` stays high in DRAIN regardless of `out_ready`. `out_data` is stable until the handshake.
- `valid_i` outside WAIT is ignored; buffers are unchanged.
- `ct*_o` are driven from the input buffers at all times. They are stable from FIRE through WAIT because nothing is written outside LOAD.
- Beat counter is ceil(log2(4N)) bits. It resets to 0 on entering LOAD and on reset, with no wrap inside a job.
- No arithmetic on data; coefficients pass through bit-exact.

## Timing
- Reset (rst=0, asynchronous):
  - state=LOAD, counters=0, all buffers=0.
  - `start_o=0`, `out_valid=0`, `out_last=0`, `out_data=0`, `t_o=q_o=0`, `busy_o=0`.
  - `in_ready=1` one cycle after deassertion.
- Reset mid-job aborts the job; no partial output is produced.
- Input throughput: one beat per cycle. Minimum LOAD duration is 4N cycles.
- `start_o` rises the cycle after the final input beat is accepted and lasts exactly 1 cycle.
- `out_valid` rises the cycle after `valid_i` is sampled.
- Output throughput: one beat per cycle while `out_ready=1`.
- `in_ready` returns 1 the cycle after the last output handshake. No overlap between jobs.
- `out_last=1` only on beat 2N-1, in the same cycle as its `out_valid`.

## Structure
- Shared package `he_pkg`:
  - `coef_t` (W bits).
  - `poly_t` (N×W packed).
  - state enum `drv_state_e` {LOAD, FIRE, WAIT, DRAIN}.
  - `LOAD_BEATS=4*N` and `DRAIN_BEATS=2*N` constants.
- One sub-module, `he_poly_buf`: an N-entry coefficient buffer with indexed single-word write, full-polynomial packed read, whole-polynomial parallel load and indexed read.
  - Instantiated 4× for inputs and 2× for results.

## Test plan
- Reset during LOAD after 5 beats, then release → `in_ready=1`, `busy_o=0`, counter 0. A full new job of 4N beats then completes normally.
- Load 4N beats with ct00=1, ct01=2, ct10=3, ct11=4 for all coefficients, `cfg_t=5`, `cfg_q=9` → `start_o` high exactly 1 cycle, 1 cycle after the last beat. `ct00_o={N{1}}` … `ct11_o={N{4}}`, `t_o=5`, `q_o=9`.
- Bursty input (`in_valid` toggling every cycle) → identical packed polynomials. `start_o` follows the 4N-th accepted beat.
- Model asserts `valid_i` 20 cycles after `start_o` with res[0][i]=i, res[1][i]=0x100+i. Hold `out_ready=1` → out_data sequence 0..N-1, 0x100..0x100+N-1; `out_last` only on the final beat; LOAD re-entered the next cycle.
- Same result with `out_ready` low for 3 cycles mid-drain → `out_data` held, no beat lost or duplicated, total of 2N beats.
- Pulse `valid_i` during LOAD and during DRAIN → no state change; the result buffer is unchanged.

Source files
------------

// File: rtl/he_pkg.sv
// he_pkg: shared sizing, types and state encoding for the ciphertext-multiply
// driver and its coefficient buffers.
//   DEGREE_N  : coefficients per polynomial (N), power of two
//   BIT_WIDTH : bits per coefficient (W)
// DEGREE_N and BIT_WIDTH must match the sizing used by the `functional` core.
package he_pkg;

    localparam int DEGREE_N  = 8;
    localparam int BIT_WIDTH = 16;

    localparam int POLY_W      = DEGREE_N * BIT_WIDTH;
    localparam int LOAD_BEATS  = 4 * DEGREE_N;
    localparam int DRAIN_BEATS = 2 * DEGREE_N;

    // Counter / index widths. Because N is a power of two, the upper bits of
    // a beat count select the polynomial and the lower bits the coefficient.
    localparam int IDX_W  = $clog2(DEGREE_N);
    localparam int CNT_W  = $clog2(LOAD_BEATS);
    localparam int DCNT_W = $clog2(DRAIN_BEATS);

    typedef logic [BIT_WIDTH-1:0] coef_t;
    typedef logic [POLY_W-1:0]    poly_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FIRE  = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } drv_state_e;

endpackage

// File: rtl/he_poly_buf.sv
// he_poly_buf: N-entry coefficient buffer for one polynomial.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (clears all entries)
//   wr_en/wr_idx/wr_data   single-coefficient write
//   ld_en/ld_data          whole-polynomial parallel load (wins over wr_en)
//   poly                   full packed contents, coefficient 0 in the LSBs
//   rd_idx/rd_data         indexed single-coefficient read (combinational)
module he_poly_buf
    import he_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [BIT_WIDTH-1:0]     wr_data,
    input  logic                     ld_en,
    input  logic [POLY_W-1:0]        ld_data,
    output logic [POLY_W-1:0]        poly,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [BIT_WIDTH-1:0]     rd_data
);

    // Held in flops rather than RAM: the whole polynomial must be visible
    // in parallel on poly at all times.
    coef_t mem_reg [DEGREE_N];

    for (genvar gi = 0; gi < DEGREE_N; gi++) begin : g_entry
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                mem_reg[gi] <= '0;
            end else if (ld_en) begin
                mem_reg[gi] <= ld_data[gi*BIT_WIDTH +: BIT_WIDTH];
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                mem_reg[gi] <= wr_data;
            end
        end

        assign poly[gi*BIT_WIDTH +: BIT_WIDTH] = mem_reg[gi];
    end

    assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/he_mul_driver.sv
// he_mul_driver: initiator for the `functional` ciphertext-multiply core.
// Collects 4N input coefficients (ct00, ct01, ct10, ct11, coefficient 0
// first), pulses start_o for one cycle, waits for valid_i, captures both
// result polynomials and streams them out (res[0] then res[1]).
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_t, cfg_q             moduli, sampled on the first input beat of a job
//   in_valid/in_ready/in_data      input coefficient stream
//   t_o, q_o                 latched moduli to the core
//   start_o                  one-cycle job start
//   ct00_o..ct11_o           packed input polynomials to the core
//   valid_i, res_i           core result handshake and polynomials
//   out_valid/out_ready/out_data/out_last   output coefficient stream
//   busy_o                   high whenever not in LOAD
module he_mul_driver
    import he_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BIT_WIDTH-1:0]     cfg_t,
    input  logic [BIT_WIDTH-1:0]     cfg_q,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BIT_WIDTH-1:0]     in_data,
    output logic [BIT_WIDTH-1:0]     t_o,
    output logic [BIT_WIDTH-1:0]     q_o,
    output logic                     start_o,
    output logic [POLY_W-1:0]        ct00_o,
    output logic [POLY_W-1:0]        ct01_o,
    output logic [POLY_W-1:0]        ct10_o,
    output logic [POLY_W-1:0]        ct11_o,
    input  logic                     valid_i,
    input  logic [1:0][POLY_W-1:0]   res_i,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BIT_WIDTH-1:0]     out_data,
    output logic                     out_last,
    output logic                     busy_o
);

    drv_state_e          state_reg, state_next;
    logic [CNT_W-1:0]    beat_cnt_reg;
    logic [DCNT_W-1:0]   drain_cnt_reg;
    logic [DCNT_W-1:0]   drain_idx_next;
    logic                ready_en_reg;
    coef_t               t_reg, q_reg;
    coef_t               out_data_reg;

    logic                accept;
    logic                last_in;
    logic                out_fire;
    logic                last_out;
    logic                capture;

    poly_t               in_poly   [4];
    coef_t               in_rd_unused [4];
    poly_t               res_poly_unused [2];
    coef_t               res_rd    [2];

    assign accept   = in_valid && in_ready;
    assign last_in  = accept && (beat_cnt_reg == CNT_W'(LOAD_BEATS - 1));
    assign out_fire = out_valid && out_ready;
    assign last_out = out_fire && (drain_cnt_reg == DCNT_W'(DRAIN_BEATS - 1));
    assign capture  = (state_reg == WAIT) && valid_i;

    // ------------------------------------------------------------------
    // State register and next-state / output decode
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        start_o    = 1'b0;
        out_valid  = 1'b0;
        busy_o     = 1'b1;
        case (state_reg)
            LOAD: begin
                // ready_en_reg keeps in_ready low until the first clock
                // after reset release.
                in_ready = ready_en_reg;
                busy_o   = 1'b0;
                if (last_in) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                start_o    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (valid_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (last_out) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    assign out_last = (state_reg == DRAIN) &&
                      (drain_cnt_reg == DCNT_W'(DRAIN_BEATS - 1));

    // ------------------------------------------------------------------
    // Counters, moduli, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_reg <= '0;
        end else if (state_reg != LOAD) begin
            beat_cnt_reg <= '0;
        end else if (last_in) begin
            beat_cnt_reg <= '0;
        end else if (accept) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_reg <= '0;
            q_reg <= '0;
        end else if (accept && (beat_cnt_reg == '0)) begin
            t_reg <= cfg_t;
            q_reg <= cfg_q;
        end
    end

    // Output word for the beat after the current one: top bit picks the
    // result polynomial, low bits the coefficient.
    assign drain_idx_next = drain_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drain_cnt_reg <= '0;
            out_data_reg  <= '0;
        end else if (capture) begin
            // The result buffers load on this same edge, so the first word
            // is taken straight from the core bus.
            drain_cnt_reg <= '0;
            out_data_reg  <= res_i[0][BIT_WIDTH-1:0];
        end else if (last_out) begin
            drain_cnt_reg <= '0;
        end else if (out_fire) begin
            drain_cnt_reg <= drain_idx_next;
            out_data_reg  <= drain_idx_next[DCNT_W-1] ? res_rd[1] : res_rd[0];
        end
    end

    assign t_o      = t_reg;
    assign q_o      = q_reg;
    assign out_data = out_data_reg;

    // ------------------------------------------------------------------
    // Buffers: four input polynomials written beat by beat, two result
    // polynomials loaded in parallel on capture.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_in_buf
        he_poly_buf u_in_buf (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (accept && (beat_cnt_reg[CNT_W-1 -: 2] == 2'(gi))),
            .wr_idx  (beat_cnt_reg[IDX_W-1:0]),
            .wr_data (in_data),
            .ld_en   (1'b0),
            .ld_data ('0),
            .poly    (in_poly[gi]),
            .rd_idx  ('0),
            .rd_data (in_rd_unused[gi])
        );
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_res_buf
        he_poly_buf u_res_buf (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (1'b0),
            .wr_idx  ('0),
            .wr_data ('0),
            .ld_en   (capture),
            .ld_data (res_i[gi]),
            .poly    (res_poly_unused[gi]),
            .rd_idx  (drain_idx_next[IDX_W-1:0]),
            .rd_data (res_rd[gi])
        );
    end

    assign ct00_o = in_poly[0];
    assign ct01_o = in_poly[1];
    assign ct10_o = in_poly[2];
    assign ct11_o = in_poly[3];

endmodule
